// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: instruction field layout,
// opcode/function encodings seen by the decoder, and the fetch FSM states.
package fetch_sequencer_pkg;

  localparam int INSTR_W = 16;

  // Opcode encodings (instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_J     = 4'd7;
  localparam logic [3:0] OP_JL    = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;
  localparam logic [3:0] OP_BLT   = 4'd10;

  // R-type function encodings (instr[2:0])
  localparam logic [2:0] FN_JR   = 3'd4;
  localparam logic [2:0] FN_HALT = 3'd7;

  // Field positions inside the instruction word
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int FN_MSB   = 2;
  localparam int FN_LSB   = 0;
  localparam int JT_MSB   = 11;
  localparam int JT_LSB   = 0;
  localparam int BOFF_MSB = 3;
  localparam int BOFF_LSB = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle. The fetch sequencer is the
// master; the instruction memory is the slave.
interface fetch_sequencer_if #(
  parameter int PC_W = 16
) ();
  import fetch_sequencer_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Combinational next-PC selection: sequential increment, absolute jump within
// the current 4K page of pc+1, register-indirect jump, and short relative
// branch. All arithmetic wraps modulo 2^PC_W.
module next_pc_sel
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [JT_MSB:0]   field,
  input  logic              jump,
  input  logic              jr,
  input  logic              branch,
  input  logic              blt,
  input  logic              halt,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic [PC_W-1:0]   rs_val,
  output logic [PC_W-1:0]   pc_plus1,
  output logic [PC_W-1:0]   next_pc
);

  // 4-bit two's-complement branch offset widened to the PC width
  function automatic logic signed [PC_W-1:0] sext_offset(
    input logic [BOFF_MSB:BOFF_LSB] off
  );
    return {{(PC_W - (BOFF_MSB - BOFF_LSB + 1)){off[BOFF_MSB]}}, off};
  endfunction

  logic signed [PC_W-1:0] br_offset;
  logic        [PC_W-1:0] br_target;
  logic        [PC_W-1:0] jump_target;
  logic                   take_branch;

  assign pc_plus1    = pc + PC_W'(1);
  assign br_offset   = sext_offset(field[BOFF_MSB:BOFF_LSB]);
  assign br_target   = pc_plus1 + $unsigned(br_offset);
  assign jump_target = {pc_plus1[PC_W-1:JT_MSB+1], field[JT_MSB:JT_LSB]};
  // blt selects the sign flag, beq the zero flag
  assign take_branch = branch & (blt ? alu_neg : alu_zero);

  // Priority mux: halt holds, jr beats plain jump, jump beats branch
  always_comb begin
    next_pc = pc_plus1;
    if (halt) begin
      next_pc = pc;
    end else if (jump && jr) begin
      next_pc = rs_val;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (take_branch) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing. One instruction is in flight at a
// time: request, wait for the memory response, hold the instruction for
// decode/execute, then pick the next PC from the decoder's control outputs.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               jr,
  input  logic               branch,
  input  logic               blt,
  input  logic               halt,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic [PC_W-1:0]    rs_val,
  output logic               halted
);

  state_t          state;
  logic            req;
  logic [PC_W-1:0] next_pc;

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .pc       (pc),
    .field    (instr[JT_MSB:0]),
    .jump     (jump),
    .jr       (jr),
    .branch   (branch),
    .blt      (blt),
    .halt     (halt),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .rs_val   (rs_val),
    .pc_plus1 (pc_plus1),
    .next_pc  (next_pc)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Fetch FSM with registered request, instruction latch and PC update.
  // Leaving HOLD raises req together with the FETCH state so the request
  // costs one cycle; only the first FETCH after reset spends an extra cycle
  // raising req, which also lets a stale pre-reset response drain unseen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req         <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (req) begin
            req   <= 1'b0;
            state <= WAIT;
          end else begin
            req <= 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_valid) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (halt) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              pc    <= next_pc;
              req   <= 1'b1;
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          halted      <= 1'b1;
          req         <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          req   <= 1'b0;
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
